// File: rtl/exec_cond_stage_pkg.sv
// -----------------------------------------------------------------------------
// exec_cond_stage_pkg
//   Shared definitions for the execute-stage entry of the ARM pipeline:
//   condition-code encodings, NZCV flag bit positions, ALUControl bit
//   assignments and the bubble value loaded into the D->E control bundle.
// -----------------------------------------------------------------------------
package exec_cond_stage_pkg;

  // ARM condition field, instruction bits [31:28].
  typedef enum logic [3:0] {
    COND_EQ = 4'h0,
    COND_NE = 4'h1,
    COND_CS = 4'h2,
    COND_CC = 4'h3,
    COND_MI = 4'h4,
    COND_PL = 4'h5,
    COND_VS = 4'h6,
    COND_VC = 4'h7,
    COND_HI = 4'h8,
    COND_LS = 4'h9,
    COND_GE = 4'hA,
    COND_LT = 4'hB,
    COND_GT = 4'hC,
    COND_LE = 4'hD,
    COND_AL = 4'hE,
    COND_NV = 4'hF
  } cond_e;

  // Bit positions inside the 4-bit {N,Z,C,V} flag vector.
  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  // Bit positions inside ALUControl.
  typedef enum int {
    ALUC_BASE_LO = 0,
    ALUC_BASE_HI = 1,
    ALUC_EOR     = 2,
    ALUC_RSB     = 3,
    ALUC_BIC     = 4
  } aluc_bit_e;

  // Single-bit controls plus condition field carried across D->E.
  typedef struct packed {
    logic       pcs;
    logic       reg_w;
    logic       mem_w;
    logic       mem_to_reg;
    logic       alu_src;
    logic       branch;
    logic       no_write;
    logic [1:0] flag_w;   // [1] N,Z enable; [0] C,V enable
    logic [3:0] cond;
  } de_ctrl_t;

  // A bubble carries no side effects; its condition is AL so it is an
  // ordinary executing no-op rather than a special case downstream.
  localparam de_ctrl_t DE_BUBBLE = '{
    pcs:        1'b0,
    reg_w:      1'b0,
    mem_w:      1'b0,
    mem_to_reg: 1'b0,
    alu_src:    1'b0,
    branch:     1'b0,
    no_write:   1'b0,
    flag_w:     2'b00,
    cond:       COND_AL
  };

endpackage

// File: rtl/exec_cond_stage_cond_check.sv
// -----------------------------------------------------------------------------
// cond_check
//   Purely combinational ARM condition evaluator.
//   Ports:
//     cond    in  4  condition field
//     flags   in  4  {N,Z,C,V}
//     cond_ex out 1  1 when the instruction is allowed to execute
// -----------------------------------------------------------------------------
module cond_check
  import exec_cond_stage_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [3:0] flags,
  output logic       cond_ex
);

  logic n, z, c, v;

  assign n = flags[FLAG_N];
  assign z = flags[FLAG_Z];
  assign c = flags[FLAG_C];
  assign v = flags[FLAG_V];

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    cond_ex = 1'b0;
    case (cond)
      COND_EQ: cond_ex = z;
      COND_NE: cond_ex = !z;
      COND_CS: cond_ex = c;
      COND_CC: cond_ex = !c;
      COND_MI: cond_ex = n;
      COND_PL: cond_ex = !n;
      COND_VS: cond_ex = v;
      COND_VC: cond_ex = !v;
      COND_HI: cond_ex = c & !z;
      COND_LS: cond_ex = !c | z;
      COND_GE: cond_ex = (n == v);
      COND_LT: cond_ex = (n != v);
      COND_GT: cond_ex = !z & (n == v);
      COND_LE: cond_ex = z | (n != v);
      COND_AL: cond_ex = 1'b1;
      default: cond_ex = 1'b0;   // NV: never execute
    endcase
  end

endmodule

// File: rtl/exec_cond_stage.sv
// -----------------------------------------------------------------------------
// exec_cond_stage
//   Execute-stage entry: registers the decoder bundle across D->E, evaluates
//   the condition field against the architectural NZCV register, gates all
//   side-effecting controls and updates NZCV from the ALU.
//   Ports:
//     clk, reset (async, active-low), FlushE
//     *D            decoder controls, condition, destination (stage D)
//     ALUFlagsE     {N,Z,C,V} from the E-stage ALU
//     PCSrcE, RegWriteE, MemWriteE, BranchTakenE   condition-gated controls
//     MemtoRegE, ALUSrcE, ALUControlE, WA3E        registered pass-through
//     CarryE, FlagsE                               architectural flag state
// -----------------------------------------------------------------------------
module exec_cond_stage
  import exec_cond_stage_pkg::*;
#(
  parameter int WA_W   = 4,
  parameter int ALUC_W = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              FlushE,
  input  logic              PCSD,
  input  logic              RegWD,
  input  logic              MemWD,
  input  logic              MemtoRegD,
  input  logic              ALUSrcD,
  input  logic              BranchD,
  input  logic              NoWriteD,
  input  logic [1:0]        FlagWD,
  input  logic [ALUC_W-1:0] ALUControlD,
  input  logic [3:0]        CondD,
  input  logic [WA_W-1:0]   WA3D,
  input  logic [3:0]        ALUFlagsE,
  output logic              PCSrcE,
  output logic              RegWriteE,
  output logic              MemWriteE,
  output logic              BranchTakenE,
  output logic              MemtoRegE,
  output logic              ALUSrcE,
  output logic [ALUC_W-1:0] ALUControlE,
  output logic [WA_W-1:0]   WA3E,
  output logic              CarryE,
  output logic [3:0]        FlagsE
);

  de_ctrl_t          ctrl_d;
  de_ctrl_t          ctrl_e;
  logic [ALUC_W-1:0] alu_control_e;
  logic [WA_W-1:0]   wa3_e;
  logic [3:0]        flags;
  logic              cond_ex_e;

  assign ctrl_d = '{
    pcs:        PCSD,
    reg_w:      RegWD,
    mem_w:      MemWD,
    mem_to_reg: MemtoRegD,
    alu_src:    ALUSrcD,
    branch:     BranchD,
    no_write:   NoWriteD,
    flag_w:     FlagWD,
    cond:       CondD
  };

  cond_check u_cond_check (
    .cond    (ctrl_e.cond),
    .flags   (flags),
    .cond_ex (cond_ex_e)
  );

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ctrl_e        <= DE_BUBBLE;
      alu_control_e <= '0;
      wa3_e         <= '0;
      flags         <= '0;
    end else begin
      if (FlushE) begin
        ctrl_e        <= DE_BUBBLE;
        alu_control_e <= '0;
        wa3_e         <= '0;
      end else begin
        ctrl_e        <= ctrl_d;
        alu_control_e <= ALUControlD;
        wa3_e         <= WA3D;
      end

      // Flag write-back belongs to the instruction already in E, so it is
      // independent of FlushE, which only affects what enters E.
      if (cond_ex_e && ctrl_e.flag_w[1]) begin
        flags[FLAG_N] <= ALUFlagsE[FLAG_N];
        flags[FLAG_Z] <= ALUFlagsE[FLAG_Z];
      end
      if (cond_ex_e && ctrl_e.flag_w[0]) begin
        flags[FLAG_C] <= ALUFlagsE[FLAG_C];
        flags[FLAG_V] <= ALUFlagsE[FLAG_V];
      end
    end
  end

  assign PCSrcE       = ctrl_e.pcs    & cond_ex_e;
  assign BranchTakenE = ctrl_e.branch & cond_ex_e;
  assign MemWriteE    = ctrl_e.mem_w  & cond_ex_e;
  assign RegWriteE    = ctrl_e.reg_w  & cond_ex_e & !ctrl_e.no_write;

  assign MemtoRegE    = ctrl_e.mem_to_reg;
  assign ALUSrcE      = ctrl_e.alu_src;
  assign ALUControlE  = alu_control_e;
  assign WA3E         = wa3_e;

  assign FlagsE       = flags;
  assign CarryE       = flags[FLAG_C];

endmodule
